// File: rtl/grey_pkg.sv
// Shared types for the column greyscale pipeline: conversion modes and FSM states.
package grey_pkg;

    typedef enum logic [1:0] {
        GREY_APPROX = 2'd0,
        GREY_BT601  = 2'd1,
        GREY_MAX    = 2'd2,
        GREY_GREEN  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // BT.601 luma weights scaled by 256.
    localparam int unsigned WEIGHT_R = 77;
    localparam int unsigned WEIGHT_G = 150;
    localparam int unsigned WEIGHT_B = 29;

endpackage

// File: rtl/grey_alu.sv
// Combinational RGB-to-grey converter for a single pixel.
module grey_alu
    import grey_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] g,
    input  logic [CW-1:0] b,
    input  logic [1:0]    mode,
    output logic [CW-1:0] y
);

    localparam int unsigned AW = CW + 8;

    logic [AW-1:0] wsum;
    logic [CW-1:0] mx;

    always_comb begin
        wsum = AW'(WEIGHT_R) * AW'(r) + AW'(WEIGHT_G) * AW'(g) + AW'(WEIGHT_B) * AW'(b);
        mx   = (r > g) ? r : g;
        if (b > mx) begin
            mx = b;
        end
        y = '0;
        case (mode_t'(mode))
            GREY_APPROX: y = (r >> 2) + (g >> 1) + (b >> 2);
            GREY_BT601:  y = wsum[AW-1:8];
            GREY_MAX:    y = mx;
            default:     y = g;
        endcase
    end

endmodule

// File: rtl/grey_col_pipe.sv
// Column greyscale converter: ROWS/P shared ALUs convert one captured column over P cycles,
// then hold it for a ready/valid consumer.
module grey_col_pipe
    import grey_pkg::*;
#(
    parameter int unsigned ROWS = 256,
    parameter int unsigned P    = 4,
    parameter int unsigned CW   = 8,
    parameter int unsigned COLS = 256,
    localparam int unsigned CLW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clock,
    input  logic                 init_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*3*CW-1:0] in_data,
    input  logic                 in_last,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROWS*CW-1:0]   out_data,
    output logic                 out_last,
    output logic [CLW-1:0]       out_col
);

    localparam int unsigned NCONV = ROWS / P;
    localparam int unsigned KW    = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PW    = 3 * CW;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q;
    logic [PW-1:0]   pix_q  [ROWS];
    logic [CW-1:0]   ybuf_q [ROWS];
    logic [1:0]      mode_q;
    logic            last_q;
    logic [CLW-1:0]  col_q;

    logic [RW-1:0]   row_idx [NCONV];
    logic [PW-1:0]   alu_in  [NCONV];
    logic [CW-1:0]   alu_y   [NCONV];
    logic            accept, handoff, k_last;

    always_comb begin
        in_ready  = init_n && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
        out_valid = (state_q == HOLD);
        accept    = in_valid && in_ready;
        handoff   = out_valid && out_ready;
        k_last    = (k_q == KW'(P - 1));
        out_last  = last_q;
        out_col   = col_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (k_last) state_d = HOLD;
            HOLD:    if (handoff) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Converter j handles rows j*P .. j*P+P-1, one per BUSY cycle.
    always_comb begin
        for (int j = 0; j < NCONV; j++) begin
            row_idx[j] = RW'(j * P + int'(k_q));
            alu_in[j]  = pix_q[row_idx[j]];
        end
    end

    for (genvar j = 0; j < NCONV; j++) begin : g_conv
        grey_alu #(
            .CW(CW)
        ) u_alu (
            .r    (alu_in[j][PW-1 -: CW]),
            .g    (alu_in[j][2*CW-1 -: CW]),
            .b    (alu_in[j][CW-1:0]),
            .mode (mode_q),
            .y    (alu_y[j])
        );
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_out
        assign out_data[r*CW +: CW] = ybuf_q[r];
    end

    always_ff @(posedge clock) begin
        if (!init_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            mode_q  <= '0;
            last_q  <= 1'b0;
            col_q   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                pix_q[r]  <= '0;
                ybuf_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q    <= '0;
                mode_q <= mode;
                last_q <= in_last;
                for (int r = 0; r < ROWS; r++) begin
                    pix_q[r] <= in_data[r*PW +: PW];
                end
            end else if (state_q == BUSY) begin
                k_q <= k_q + 1'b1;
            end
            if (state_q == BUSY) begin
                for (int j = 0; j < NCONV; j++) begin
                    ybuf_q[row_idx[j]] <= alu_y[j];
                end
            end
            // last_q still describes the column being handed off, even on a same-cycle accept.
            if (handoff) begin
                col_q <= (last_q || (col_q == CLW'(COLS - 1))) ? '0 : col_q + 1'b1;
            end
        end
    end

endmodule
